// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, branch condition codes, flag layout and
// the per-opcode flag update mask.
package wisc_pkg;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;

  typedef enum logic [2:0] {
    CccNe = 3'b000,
    CccEq = 3'b001,
    CccGt = 3'b010,
    CccLt = 3'b011,
    CccGe = 3'b100,
    CccLe = 3'b101,
    CccOv = 3'b110,
    CccUn = 3'b111
  } ccc_e;

  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic {StIdle, StResolve} bru_state_e;

  // Which of {N,Z,V} an opcode writes.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OpAdd, OpSub:               m = 3'b111;
      OpXor, OpSll, OpSra, OpRor: m[FlagZ] = 1'b1;
      default:                    m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluation on the committed {N,Z,V} flags.
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] flags_i,
  input  logic [2:0] ccc_i,
  output logic       take_o
);

  logic n, z, v;
  assign n = flags_i[FlagN];
  assign z = flags_i[FlagZ];
  assign v = flags_i[FlagV];

  always_comb begin
    take_o = 1'b0;
    unique case (ccc_e'(ccc_i))
      CccNe: take_o = ~z;
      CccEq: take_o = z;
      CccGt: take_o = ~z & ~n;
      CccLt: take_o = n;
      CccGe: take_o = z | ~n;
      CccLe: take_o = n | z;
      CccOv: take_o = v;
      CccUn: take_o = 1'b1;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Flag register, flag-hazard stall and registered branch redirect for the
// WISC decode stage.
module branch_resolve_unit
  import wisc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       ex_flags,
  input  logic             id_valid,
  input  logic             id_is_b,
  input  logic             id_is_br,
  input  logic [2:0]       id_ccc,
  input  logic [8:0]       id_imm9,
  input  logic [15:0]      id_pc_plus2,
  input  logic [15:0]      id_rs_data,
  output logic [2:0]       flags_q,
  output logic             stall_o,
  output logic             redirect_o,
  output logic [15:0]      target_o,
  output logic [CNT_W-1:0] taken_cnt
);

  bru_state_e       state_q, state_d;
  logic [2:0]       flags_d, ex_mask;
  logic             redirect_q, redirect_d;
  logic [15:0]      target_q, target_d, br_target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_branch, take;

  assign ex_mask   = flag_mask(ex_opcode);
  assign is_branch = id_valid & (id_is_b | id_is_br);
  assign stall_o   = is_branch & (id_ccc != CccUn) & ex_valid & (|ex_mask);

  cond_eval u_cond_eval (
    .flags_i (flags_q),
    .ccc_i   (id_ccc),
    .take_o  (take)
  );

  // BR takes priority when both branch kinds are flagged.
  assign br_target = id_is_br ? id_rs_data
                              : id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};

  always_comb begin
    flags_d    = flags_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    cnt_d      = cnt_q;
    if (ex_valid) flags_d = (flags_q & ~ex_mask) | (ex_flags & ex_mask);
    unique case (state_q)
      StIdle: begin
        if (is_branch && !stall_o) begin
          state_d = StResolve;
          if (take) begin
            redirect_d = 1'b1;
            target_d   = br_target;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StResolve: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      flags_q    <= 3'b000;
      redirect_q <= 1'b0;
      target_q   <= 16'h0000;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
    end
  end

  assign redirect_o = redirect_q;
  assign target_o   = target_q;
  assign taken_cnt  = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a behavioural model of flags, hazards and branches.
module tb_branch_resolve_unit;

  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, id_valid, id_is_b, id_is_br;
  logic [3:0]    ex_opcode;
  logic [2:0]    ex_flags, id_ccc;
  logic [8:0]    id_imm9;
  logic [15:0]   id_pc_plus2, id_rs_data;
  logic [2:0]    flags_q;
  logic          stall_o, redirect_o;
  logic [15:0]   target_o;
  logic [CW-1:0] taken_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_n, m_z, m_v, m_busy, m_redir;
  int m_target, m_cnt;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_flags    (ex_flags),
    .id_valid    (id_valid),
    .id_is_b     (id_is_b),
    .id_is_br    (id_is_br),
    .id_ccc      (id_ccc),
    .id_imm9     (id_imm9),
    .id_pc_plus2 (id_pc_plus2),
    .id_rs_data  (id_rs_data),
    .flags_q     (flags_q),
    .stall_o     (stall_o),
    .redirect_o  (redirect_o),
    .target_o    (target_o),
    .taken_cnt   (taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit writes_nzv(input int op);
    return op == 0 || op == 1;
  endfunction

  function automatic bit writes_z_only(input int op);
    return op == 2 || op == 4 || op == 5 || op == 6;
  endfunction

  function automatic bit model_stall();
    bit br = id_valid && (id_is_b || id_is_br);
    int op = int'(ex_opcode);
    return br && id_ccc != 3'd7 && ex_valid && (writes_nzv(op) || writes_z_only(op));
  endfunction

  function automatic bit model_take(input int ccc);
    case (ccc)
      0: return !m_z;
      1: return m_z;
      2: return !m_z && !m_n;
      3: return m_n;
      4: return m_z || (!m_z && !m_n);
      5: return m_n || m_z;
      6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int model_target();
    int off;
    if (id_is_br) return int'(id_rs_data);
    off = int'(id_imm9);
    if (off >= 256) off = off - 512;
    return (int'(id_pc_plus2) + off * 2) & 16'hFFFF;
  endfunction

  task automatic model_reset();
    {m_n, m_z, m_v, m_busy, m_redir} = '0;
    m_target = 0;
    m_cnt = 0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    bit stall = model_stall();
    bit br = id_valid && (id_is_b || id_is_br) && !stall;
    int op = int'(ex_opcode);
    m_redir = 1'b0;
    if (!m_busy && br) begin
      m_busy = 1'b1;
      if (model_take(int'(id_ccc))) begin
        m_redir = 1'b1;
        m_target = model_target();
        if (m_cnt < CMAX) m_cnt++;
      end
    end else begin
      m_busy = 1'b0;
    end
    if (ex_valid) begin
      if (writes_nzv(op)) {m_n, m_z, m_v} = {ex_flags[2], ex_flags[1], ex_flags[0]};
      else if (writes_z_only(op)) m_z = ex_flags[1];
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_opcode = 4'h3; ex_flags = 0;
    id_valid = 0; id_is_b = 0; id_is_br = 0; id_ccc = 0;
    id_imm9 = 0; id_pc_plus2 = 0; id_rs_data = 0;
  endtask

  task automatic set_ex(input bit v, input logic [3:0] op, input logic [2:0] f);
    ex_valid = v; ex_opcode = op; ex_flags = f;
  endtask

  task automatic set_id(input bit v, input bit b, input bit br, input logic [2:0] ccc,
                        input logic [8:0] imm, input logic [15:0] pc, input logic [15:0] rs);
    id_valid = v; id_is_b = b; id_is_br = br; id_ccc = ccc;
    id_imm9 = imm; id_pc_plus2 = pc; id_rs_data = rs;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    total++; if (flags_q !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", flags_q); end
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%b exp=0", redirect_o); end
    total++; if (target_o !== 16'h0) begin bad++; $display("FAIL rst_target got=%h exp=0000", target_o); end
    total++; if (taken_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", taken_cnt); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_flags();
    set_ex(1, 4'h0, 3'b110);
    tick();
    total++; if (flags_q !== 3'b110) begin bad++; $display("FAIL add_flags got=%b exp=110", flags_q); end
    set_ex(1, 4'h2, 3'b001);
    tick();
    total++; if (flags_q !== 3'b100) begin bad++; $display("FAIL xor_flags got=%b exp=100", flags_q); end
    set_ex(1, 4'hA, 3'b011);
    tick();
    total++; if (flags_q !== 3'b100) begin bad++; $display("FAIL nonwriter_flags got=%b exp=100", flags_q); end
    set_ex(0, 4'h0, 3'b011);
    tick();
    total++; if (flags_q !== 3'b100) begin bad++; $display("FAIL bubble_flags got=%b exp=100", flags_q); end
  endtask

  task automatic test_branch_b();
    set_ex(1, 4'h0, 3'b010);
    tick();
    set_ex(0, 4'h0, 3'b000);
    set_id(1, 1, 0, 3'b001, 9'h1FF, 16'h0010, 16'h0);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b_eq_stall got=%b exp=0", stall_o); end
    tick();
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL b_eq_redirect got=%b exp=1", redirect_o); end
    total++; if (target_o !== 16'h000E) begin bad++; $display("FAIL b_eq_target got=%h exp=000e", target_o); end
    id_valid = 0;
    tick();
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL b_eq_pulse got=%b exp=0", redirect_o); end
    total++; if (taken_cnt !== 4'd1) begin bad++; $display("FAIL b_eq_cnt got=%0d exp=1", taken_cnt); end
  endtask

  task automatic test_stall();
    set_ex(1, 4'h1, 3'b100);
    set_id(1, 1, 0, 3'b011, 9'h004, 16'h0100, 16'h0);
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL hazard_stall got=%b exp=1", stall_o); end
    tick();
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL hazard_noresolve got=%b exp=0", redirect_o); end
    set_ex(0, 4'h0, 3'b000);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL hazard_release got=%b exp=0", stall_o); end
    tick();
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL hazard_redirect got=%b exp=1", redirect_o); end
    total++; if (target_o !== 16'h0108) begin bad++; $display("FAIL hazard_target got=%h exp=0108", target_o); end
    idle_inputs();
    tick();
    // Non-writers never cause a hazard.
    set_ex(1, 4'h3, 3'b111);
    set_id(1, 0, 1, 3'b000, 9'h0, 16'h0, 16'h4444);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL op3_stall got=%b exp=0", stall_o); end
    ex_opcode = 4'hA;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL opA_stall got=%b exp=0", stall_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_br();
    set_ex(1, 4'h0, 3'b000);
    tick();
    set_ex(0, 4'h0, 3'b000);
    set_id(1, 0, 1, 3'b110, 9'h0, 16'h0, 16'h1234);
    tick();
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL br_ov_redirect got=%b exp=0", redirect_o); end
    total++; if (target_o !== 16'h0108) begin bad++; $display("FAIL br_ov_target_hold got=%h exp=0108", target_o); end
    id_valid = 0;
    tick();
    set_id(1, 1, 1, 3'b111, 9'h010, 16'h0, 16'h1234);
    tick();
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL br_un_redirect got=%b exp=1", redirect_o); end
    total++; if (target_o !== 16'h1234) begin bad++; $display("FAIL br_un_target got=%h exp=1234", target_o); end
    idle_inputs();
    tick();
    set_id(1, 1, 0, 3'b111, 9'h002, 16'hFFFE, 16'h0);
    set_ex(1, 4'h0, 3'b111);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL un_commit_stall got=%b exp=0", stall_o); end
    tick();
    total++; if (target_o !== 16'h0002) begin bad++; $display("FAIL wrap_target got=%h exp=0002", target_o); end
    total++; if (flags_q !== 3'b111) begin bad++; $display("FAIL un_commit_flags got=%b exp=111", flags_q); end
    idle_inputs();
    tick();
    total++; if (taken_cnt !== 4'd4) begin bad++; $display("FAIL br_cnt got=%0d exp=4", taken_cnt); end
  endtask

  task automatic test_reset_mid();
    set_id(1, 0, 1, 3'b111, 9'h0, 16'h0, 16'hBEEF);
    tick();
    total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", redirect_o); end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL mid_redirect got=%b exp=0", redirect_o); end
    total++; if (flags_q !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b exp=000", flags_q); end
    total++; if (taken_cnt !== '0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", taken_cnt); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 5; i++) begin
      set_id(1, 0, 1, 3'b111, 9'h0, 16'h0, 16'(i));
      tick();
      id_valid = 0;
      tick();
    end
    total++; if (taken_cnt !== CW'(CMAX)) begin bad++; $display("FAIL sat_cnt got=%0d exp=%0d", taken_cnt, CMAX); end
    total++; if (target_o !== 16'(CMAX + 4)) begin bad++; $display("FAIL sat_target got=%h exp=%h", target_o, 16'(CMAX + 4)); end
  endtask

  task automatic test_random();
    logic [3:0] ops [0:7];
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h3, 4'hA};
    rst_n = 0;
    model_reset();
    idle_inputs();
    #3;
    @(negedge clk);
    rst_n = 1;
    tick();
    for (int i = 0; i < 600; i++) begin
      ex_valid    = ($urandom_range(0, 2) != 0);
      ex_opcode   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      ex_flags    = 3'($urandom);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_is_b     = 1'($urandom);
      id_is_br    = 1'($urandom);
      id_ccc      = 3'($urandom);
      id_imm9     = 9'($urandom);
      id_pc_plus2 = 16'($urandom);
      id_rs_data  = 16'($urandom);
      #1;
      total++;
      if (stall_o !== model_stall()) begin
        bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall_o, model_stall());
      end
      tick();
      total++;
      if (redirect_o !== m_redir) begin
        bad++; $display("FAIL rnd_redirect cyc=%0d got=%b exp=%b", i, redirect_o, m_redir);
      end
      total++;
      if (target_o !== 16'(m_target)) begin
        bad++; $display("FAIL rnd_target cyc=%0d got=%h exp=%h", i, target_o, 16'(m_target));
      end
      total++;
      if (flags_q !== {m_n, m_z, m_v}) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, flags_q, {m_n, m_z, m_v});
      end
      if (!redirect_o) begin
        total++;
        if (taken_cnt !== CW'(m_cnt)) begin
          bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, taken_cnt, m_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_branch_b();
    test_stall();
    test_branch_br();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
